pipe_hazard_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage SIMD pipeline (IF, ID, EXE, MEM, WB).
- Mirrors the destination, write-back and load flags of the instructions in EXE, MEM and WB in an internal 3-entry scoreboard.
- Forwards in-flight results to the decode operands, generates load-use stalls, and flushes on taken branches.
- Sits beside decode and drives the PC enable, the IF/ID hold/flush and the ID/EXE bubble.

---
 rtl/pipe_hazard_unit.sv | 145 ++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage SIMD pipeline: EXE/MEM/WB scoreboard,
// operand forwarding, load-use stall and branch flush. Define HAZARD_STATS_EN for stall/flush counters.
module pipe_hazard_unit #(
  parameter int DATA_W = 16,
  parameter int LANES  = 1,
  parameter int REG_AW = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_rs_a,
  input  logic [REG_AW-1:0]         id_rs_b,
  input  logic                      id_use_a,
  input  logic                      id_use_b,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_wb,
  input  logic                      id_mem_rd,
  input  logic [LANES*DATA_W-1:0]   rf_a,
  input  logic [LANES*DATA_W-1:0]   rf_b,
  input  logic [LANES*DATA_W-1:0]   exe_result,
  input  logic [LANES*DATA_W-1:0]   mem_result,
  input  logic [LANES*DATA_W-1:0]   wb_data,
  input  logic                      branch_taken,
  output logic [LANES*DATA_W-1:0]   op_a,
  output logic [LANES*DATA_W-1:0]   op_b,
  output logic [1:0]                fwd_sel_a,
  output logic [1:0]                fwd_sel_b,
  output logic                      pc_en,
  output logic                      if_id_hold,
  output logic                      if_id_flush,
  output logic                      id_exe_bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
`endif
);

  localparam int W = LANES * DATA_W;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              wb;
    logic              mrd;
  } sb_t;

  sb_t  exe_q, mem_q, wb_q, exe_d;
  logic hit_ea, hit_ma, hit_wa, hit_eb, hit_mb, hit_wb;
  logic stall;
  logic [1:0] sel_a, sel_b;

  function automatic logic hit(input sb_t e, input logic [REG_AW-1:0] rs,
                               input logic use_x, input logic vld_id);
    return e.vld && e.wb && (e.rd == rs) && use_x && vld_id;
  endfunction

  // Youngest match wins; a load match in EXE/MEM stalls, so its select is irrelevant.
  function automatic logic [1:0] pick_sel(input logic he, input logic hm, input logic hw,
                                          input logic emrd, input logic mmrd);
    if (he)      return emrd ? 2'd0 : 2'd1;
    else if (hm) return mmrd ? 2'd0 : 2'd2;
    else if (hw) return 2'd3;
    else         return 2'd0;
  endfunction

  function automatic logic [W-1:0] fwd_mux(input logic [1:0] sel, input logic [W-1:0] rf,
                                           input logic [W-1:0] ex, input logic [W-1:0] mm,
                                           input logic [W-1:0] wb);
    case (sel)
      2'd1:    return ex;
      2'd2:    return mm;
      2'd3:    return wb;
      default: return rf;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    return (en && (c != 32'hFFFF_FFFF)) ? c + 32'd1 : c;
  endfunction

  always_comb begin
    hit_ea = hit(exe_q, id_rs_a, id_use_a, id_valid);
    hit_ma = hit(mem_q, id_rs_a, id_use_a, id_valid);
    hit_wa = hit(wb_q,  id_rs_a, id_use_a, id_valid);
    hit_eb = hit(exe_q, id_rs_b, id_use_b, id_valid);
    hit_mb = hit(mem_q, id_rs_b, id_use_b, id_valid);
    hit_wb = hit(wb_q,  id_rs_b, id_use_b, id_valid);
    stall  = ((hit_ea || hit_eb) && exe_q.mrd) || ((hit_ma || hit_mb) && mem_q.mrd);
    sel_a  = pick_sel(hit_ea, hit_ma, hit_wa, exe_q.mrd, mem_q.mrd);
    sel_b  = pick_sel(hit_eb, hit_mb, hit_wb, exe_q.mrd, mem_q.mrd);
    exe_d  = {id_valid && !stall && !branch_taken, id_rd, id_wb, id_mem_rd};
  end

  // A taken branch overrides a stall: the PC must load the target this cycle.
  always_comb begin
    pc_en         = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b1;
    id_exe_bubble = 1'b1;
    fwd_sel_a     = 2'd0;
    fwd_sel_b     = 2'd0;
    if (!reset) begin
      pc_en         = !stall || branch_taken;
      if_id_hold    = stall && !branch_taken;
      if_id_flush   = branch_taken;
      id_exe_bubble = stall || branch_taken;
      fwd_sel_a     = sel_a;
      fwd_sel_b     = sel_b;
    end
    op_a = fwd_mux(fwd_sel_a, rf_a, exe_result, mem_result, wb_data);
    op_b = fwd_mux(fwd_sel_b, rf_b, exe_result, mem_result, wb_data);
  end

  // Scoreboard stage boundary: ID -> EXE -> MEM -> WB; only valid bits are reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      exe_q.vld <= 1'b0;
      mem_q.vld <= 1'b0;
      wb_q.vld  <= 1'b0;
    end else begin
      exe_q <= exe_d;
      mem_q <= exe_q;
      wb_q  <= mem_q;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= sat_inc(stall_cnt_q, stall);
      flush_cnt_q <= sat_inc(flush_cnt_q, branch_taken);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit (LANES = 4): directed hazard scenarios plus
// randomized traffic compared against an instruction-history reference model.
module tb_pipe_hazard_unit;
  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int REG_AW = 4;
  localparam int W      = LANES * DATA_W;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid, id_use_a, id_use_b, id_wb, id_mem_rd, branch_taken;
  logic [3:0]    id_rs_a, id_rs_b, id_rd;
  logic [W-1:0]  rf_a, rf_b, exe_result, mem_result, wb_data;
  logic [W-1:0]  op_a, op_b;
  logic [1:0]    fwd_sel_a, fwd_sel_b;
  logic          pc_en, if_id_hold, if_id_flush, id_exe_bubble;
`ifdef HAZARD_STATS_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: the last three issued instructions, index 0 = youngest (EXE).
  bit          mv[3];
  logic [3:0]  mrd[3];
  bit          mwb[3];
  bit          mld[3];
  int unsigned m_scnt, m_fcnt;
  bit          e_stall, e_pc, e_hold, e_flush, e_bub;
  logic [1:0]  e_sela, e_selb;
  logic [W-1:0] e_opa, e_opb;

  pipe_hazard_unit #(.DATA_W(DATA_W), .LANES(LANES), .REG_AW(REG_AW)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .id_rd(id_rd), .id_wb(id_wb), .id_mem_rd(id_mem_rd),
    .rf_a(rf_a), .rf_b(rf_b), .exe_result(exe_result), .mem_result(mem_result),
    .wb_data(wb_data), .branch_taken(branch_taken),
    .op_a(op_a), .op_b(op_b), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .pc_en(pc_en), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_exe_bubble(id_exe_bubble)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] pickv(input logic [1:0] s, input logic [W-1:0] rf);
    case (s)
      2'd1:    return exe_result;
      2'd2:    return mem_result;
      2'd3:    return wb_data;
      default: return rf;
    endcase
  endfunction

  function automatic void model_eval();
    int fa, fb;
    bit sa, sb;
    fa = -1; fb = -1; sa = 0; sb = 0;
    for (int i = 0; i < 3; i++) begin
      if (mv[i] && mwb[i] && mrd[i] == id_rs_a && id_use_a && id_valid) begin
        if (fa < 0) fa = i;
        if (i < 2 && mld[i]) sa = 1;
      end
      if (mv[i] && mwb[i] && mrd[i] == id_rs_b && id_use_b && id_valid) begin
        if (fb < 0) fb = i;
        if (i < 2 && mld[i]) sb = 1;
      end
    end
    e_stall = sa || sb;
    e_sela  = (fa < 0) ? 2'd0 : 2'(fa + 1);
    e_selb  = (fb < 0) ? 2'd0 : 2'(fb + 1);
    if (reset) begin
      e_pc = 0; e_hold = 0; e_flush = 1; e_bub = 1; e_sela = 2'd0; e_selb = 2'd0;
    end else begin
      e_pc    = !(e_stall && !branch_taken);
      e_hold  = e_stall && !branch_taken;
      e_flush = branch_taken;
      e_bub   = e_stall || branch_taken;
    end
    e_opa = pickv(e_sela, rf_a);
    e_opb = pickv(e_selb, rf_b);
  endfunction

  function automatic void model_update();
    if (reset) begin
      for (int i = 0; i < 3; i++) mv[i] = 0;
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      for (int i = 2; i > 0; i--) begin
        mv[i] = mv[i-1]; mrd[i] = mrd[i-1]; mwb[i] = mwb[i-1]; mld[i] = mld[i-1];
      end
      mv[0]  = id_valid && !e_stall && !branch_taken;
      mrd[0] = id_rd; mwb[0] = id_wb; mld[0] = id_mem_rd;
      if (e_stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
      if (branch_taken && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
    end
  endfunction

  task automatic step();
    model_eval();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle_id();
    id_valid = 0; id_use_a = 0; id_use_b = 0; id_wb = 0; id_mem_rd = 0;
    id_rs_a = 4'd0; id_rs_b = 4'd0; id_rd = 4'd0; branch_taken = 0;
  endtask

  task automatic issue(input logic [3:0] rd, input logic wb, input logic ld);
    idle_id();
    id_valid = 1; id_rd = rd; id_wb = wb; id_mem_rd = ld;
    step();
  endtask

  task automatic read_regs(input logic [3:0] ra, input logic ua, input logic [3:0] rb, input logic ub);
    idle_id();
    id_valid = 1; id_rs_a = ra; id_use_a = ua; id_rs_b = rb; id_use_b = ub;
    id_rd = 4'hF; id_wb = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle_id();
    step(); step();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; read_regs(4'd1, 1, 4'd2, 1);
    rf_a = {$urandom, $urandom}; rf_b = {$urandom, $urandom};
    #1;
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL reset_pc_en got=%b exp=0", pc_en); end
    checks++; if (if_id_hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", if_id_hold); end
    checks++; if (if_id_flush !== 1'b1) begin failures++; $display("FAIL reset_flush got=%b exp=1", if_id_flush); end
    checks++; if (id_exe_bubble !== 1'b1) begin failures++; $display("FAIL reset_bubble got=%b exp=1", id_exe_bubble); end
    checks++; if (op_a !== rf_a || fwd_sel_a !== 2'd0) begin failures++; $display("FAIL reset_op_a got=%h sel=%0d exp=%h sel=0", op_a, fwd_sel_a, rf_a); end
    step(); step();
    reset = 0;
    #1;
    checks++; if (pc_en !== 1'b1 || id_exe_bubble !== 1'b0 || if_id_flush !== 1'b0) begin
      failures++; $display("FAIL post_reset_ctrl got pc=%b bub=%b fl=%b exp pc=1 bub=0 fl=0", pc_en, id_exe_bubble, if_id_flush); end
    checks++; if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
      failures++; $display("FAIL post_reset_sel got a=%0d b=%0d exp 0 0", fwd_sel_a, fwd_sel_b); end
    step();
  endtask

  task automatic test_alu_chain();
    do_reset();
    exe_result = {4{16'h0005}}; mem_result = {4{16'h0BAD}}; wb_data = {4{16'h0DEF}};
    issue(4'd1, 1, 0);
    read_regs(4'd1, 1, 4'd0, 0);
    #1;
    checks++; if (fwd_sel_a !== 2'd1 || op_a !== {4{16'h0005}}) begin
      failures++; $display("FAIL alu_chain got sel=%0d op=%h exp sel=1 op=%h", fwd_sel_a, op_a, {4{16'h0005}}); end
    checks++; if (pc_en !== 1'b1 || id_exe_bubble !== 1'b0 || if_id_hold !== 1'b0) begin
      failures++; $display("FAIL alu_chain_nostall got pc=%b bub=%b hold=%b exp 1 0 0", pc_en, id_exe_bubble, if_id_hold); end
    issue(4'd0, 1, 0);
    read_regs(4'd0, 0, 4'd0, 1);
    #1;
    checks++; if (fwd_sel_b !== 2'd1 || op_b !== exe_result) begin
      failures++; $display("FAIL reg0_fwd got sel=%0d op=%h exp sel=1 op=%h", fwd_sel_b, op_b, exe_result); end
    step();
  endtask

  task automatic test_distance();
    do_reset();
    exe_result = {4{16'h7777}}; mem_result = {4{16'h00AA}}; wb_data = {4{16'h00AA}};
    issue(4'd2, 1, 0);
    idle_id(); step();
    read_regs(4'd0, 0, 4'd2, 1);
    #1;
    checks++; if (fwd_sel_b !== 2'd2 || op_b !== {4{16'h00AA}} || pc_en !== 1'b1) begin
      failures++; $display("FAIL distance2 got sel=%0d op=%h pc=%b exp sel=2 op=%h pc=1", fwd_sel_b, op_b, pc_en, {4{16'h00AA}}); end
    step();
    #1;
    checks++; if (fwd_sel_b !== 2'd3 || op_b !== {4{16'h00AA}} || pc_en !== 1'b1) begin
      failures++; $display("FAIL distance3 got sel=%0d op=%h pc=%b exp sel=3 op=%h pc=1", fwd_sel_b, op_b, pc_en, {4{16'h00AA}}); end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    wb_data = {$urandom, $urandom}; exe_result = {$urandom, $urandom}; mem_result = {$urandom, $urandom};
    issue(4'd3, 1, 1);
    read_regs(4'd3, 1, 4'd0, 0);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (pc_en !== 1'b0 || id_exe_bubble !== 1'b1 || if_id_hold !== 1'b1) begin
        failures++; $display("FAIL load_use_stall%0d got pc=%b bub=%b hold=%b exp 0 1 1", k, pc_en, id_exe_bubble, if_id_hold); end
      step();
    end
    #1;
    checks++; if (fwd_sel_a !== 2'd3 || op_a !== wb_data || pc_en !== 1'b1) begin
      failures++; $display("FAIL load_use_fwd got sel=%0d op=%h pc=%b exp sel=3 op=%h pc=1", fwd_sel_a, op_a, pc_en, wb_data); end
    step();
  endtask

  task automatic test_priority();
    do_reset();
    mem_result = {4{16'h1111}}; exe_result = {4{16'h2222}}; wb_data = {4{16'h3333}};
    issue(4'd4, 1, 0);
    issue(4'd4, 1, 0);
    read_regs(4'd4, 1, 4'd0, 0);
    #1;
    checks++; if (fwd_sel_a !== 2'd1 || op_a !== {4{16'h2222}}) begin
      failures++; $display("FAIL priority got sel=%0d op=%h exp sel=1 op=%h", fwd_sel_a, op_a, {4{16'h2222}}); end
    step();
  endtask

  task automatic test_branch();
    do_reset();
    issue(4'd5, 1, 1);
    read_regs(4'd5, 1, 4'd0, 0);
    id_rd = 4'd6; id_wb = 1; branch_taken = 1;
    #1;
    checks++; if (if_id_flush !== 1'b1 || pc_en !== 1'b1 || if_id_hold !== 1'b0 || id_exe_bubble !== 1'b1) begin
      failures++; $display("FAIL branch_over_stall got fl=%b pc=%b hold=%b bub=%b exp 1 1 0 1", if_id_flush, pc_en, if_id_hold, id_exe_bubble); end
    step();
    read_regs(4'd6, 1, 4'd0, 0);
    #1;
    checks++; if (fwd_sel_a !== 2'd0 || pc_en !== 1'b1) begin
      failures++; $display("FAIL branch_exe_invalid got sel=%0d pc=%b exp sel=0 pc=1", fwd_sel_a, pc_en); end
    step();
  endtask

  task automatic test_reset_in_stall();
    do_reset();
    rf_a = {$urandom, $urandom}; wb_data = {$urandom, $urandom};
    issue(4'd3, 1, 1);
    read_regs(4'd3, 1, 4'd0, 0);
    #1;
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL pre_reset_stall got pc=%b exp 0", pc_en); end
    reset = 1;
    #1;
    checks++; if (pc_en !== 1'b0 || if_id_flush !== 1'b1 || op_a !== rf_a) begin
      failures++; $display("FAIL reset_in_stall got pc=%b fl=%b op=%h exp pc=0 fl=1 op=%h", pc_en, if_id_flush, op_a, rf_a); end
    step();
    reset = 0;
    #1;
    checks++; if (pc_en !== 1'b1 || if_id_hold !== 1'b0 || fwd_sel_a !== 2'd0 || op_a !== rf_a) begin
      failures++; $display("FAIL stall_cleared got pc=%b hold=%b sel=%0d op=%h exp pc=1 hold=0 sel=0 op=%h", pc_en, if_id_hold, fwd_sel_a, op_a, rf_a); end
`ifdef HAZARD_STATS_EN
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL stall_cnt_reset got=%0d exp=0", stall_cnt); end
`endif
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      reset        = ($urandom_range(0, 99) < 3);
      id_valid     = ($urandom_range(0, 99) < 85);
      id_rs_a      = 4'($urandom_range(0, 3));
      id_rs_b      = 4'($urandom_range(0, 3));
      id_use_a     = 1'($urandom);
      id_use_b     = 1'($urandom);
      id_rd        = 4'($urandom_range(0, 3));
      id_wb        = ($urandom_range(0, 99) < 80);
      id_mem_rd    = ($urandom_range(0, 99) < 30);
      branch_taken = ($urandom_range(0, 99) < 10);
      rf_a = {$urandom, $urandom}; rf_b = {$urandom, $urandom};
      exe_result = {$urandom, $urandom}; mem_result = {$urandom, $urandom}; wb_data = {$urandom, $urandom};
      #1;
      model_eval();
      checks++; if ({pc_en, if_id_hold, if_id_flush, id_exe_bubble} !== {e_pc, e_hold, e_flush, e_bub}) begin
        failures++; $display("FAIL rand_ctrl n=%0d got=%b exp=%b", n, {pc_en, if_id_hold, if_id_flush, id_exe_bubble}, {e_pc, e_hold, e_flush, e_bub}); end
      if (reset || !e_stall) begin
        checks++; if (fwd_sel_a !== e_sela || op_a !== e_opa) begin
          failures++; $display("FAIL rand_op_a n=%0d got sel=%0d op=%h exp sel=%0d op=%h", n, fwd_sel_a, op_a, e_sela, e_opa); end
        checks++; if (fwd_sel_b !== e_selb || op_b !== e_opb) begin
          failures++; $display("FAIL rand_op_b n=%0d got sel=%0d op=%h exp sel=%0d op=%h", n, fwd_sel_b, op_b, e_selb, e_opb); end
      end
`ifdef HAZARD_STATS_EN
      checks++; if (stall_cnt !== m_scnt || flush_cnt !== m_fcnt) begin
        failures++; $display("FAIL rand_stats n=%0d got s=%0d f=%0d exp s=%0d f=%0d", n, stall_cnt, flush_cnt, m_scnt, m_fcnt); end
`endif
      step();
    end
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin mv[i] = 0; mrd[i] = 4'd0; mwb[i] = 0; mld[i] = 0; end
    m_scnt = 0; m_fcnt = 0;
    reset = 1; idle_id();
    rf_a = '0; rf_b = '0; exe_result = '0; mem_result = '0; wb_data = '0;
    test_reset();
    test_alu_chain();
    test_distance();
    test_load_use();
    test_priority();
    test_branch();
    test_reset_in_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
